// File: rtl/cxl_llr_pkg.sv
// CXL link-layer retry buffer: shared types, defaults and modular helpers.
package cxl_llr_pkg;

  typedef enum logic [1:0] {
    LLR_IDLE,
    LLR_SETUP,
    LLR_REPLAY
  } llr_state_e;

  localparam int unsigned LLR_FLIT_W = 528;
  localparam int unsigned LLR_DEPTH  = 256;
  // Wide enough for DEPTH up to 1024 plus a count bit.
  localparam int unsigned LLR_DW     = 11;

  // (a - b) mod (wrap + 1), for a, b in [0, wrap].
  function automatic logic [LLR_DW-1:0] llr_mod_dist(input logic [LLR_DW-1:0] a,
                                                     input logic [LLR_DW-1:0] b,
                                                     input logic [LLR_DW-1:0] wrap);
    if (a >= b) return a - b;
    return a + wrap + LLR_DW'(1) - b;
  endfunction

endpackage

// File: rtl/cxl_llr_ram.sv
// Simple dual-port RAM for the retry buffer: sync write, sync read, 1-cycle latency, no reset.
module cxl_llr_ram #(
  parameter int unsigned W     = 528,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem [DEPTH];

  // Read data only changes on a read strobe, so it holds across replay stalls.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/cxl_llr_buffer.sv
// CXL link-layer retry buffer: stores sent flits by sequence number, frees them on
// full-ack counts and replays from a requested ESEQ.
// Optional high-water tracking is built when LLRB_HIGH_WATER_EN is defined.
module cxl_llr_buffer
  import cxl_llr_pkg::*;
#(
  parameter int unsigned FLIT_W = LLR_FLIT_W,
  parameter int unsigned DEPTH  = LLR_DEPTH,
  parameter int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [PTR_W-1:0]  i_wrap_value,
  input  logic              i_wr_en,
  input  logic [FLIT_W-1:0] i_wr_flit,
  output logic              o_wr_ready,
  output logic [PTR_W-1:0]  o_wr_ptr,
  input  logic              i_ack_valid,
  input  logic [PTR_W-1:0]  i_ack_num,
  input  logic              i_replay_req,
  input  logic [PTR_W-1:0]  i_replay_eseq,
  output logic              o_rd_valid,
  input  logic              i_rd_ready,
  output logic [FLIT_W-1:0] o_rd_flit,
  output logic [PTR_W-1:0]  o_rd_seq,
  output logic              o_replay_active,
  output logic              o_replay_done,
  output logic              o_replay_err,
  output logic [PTR_W:0]    o_consumed,
  output logic [PTR_W:0]    o_high_water,
  input  logic              i_hwm_clr
);

  localparam int unsigned CW = PTR_W + 1;

  llr_state_e       state_q, state_d;
  logic [PTR_W-1:0] wrap_q, wrap_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [CW-1:0]    count_q, count_d;
  logic             err_q, err_d;
  logic             done_q, done_d;

  logic [CW-1:0]     depth_eff;
  logic              wr_acc;
  logic [CW-1:0]     n_ack;
  logic [LLR_DW-1:0] rd_dist, eseq_dist;
  logic              ram_re;
  logic [PTR_W-1:0]  ram_raddr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p,
                                               input logic [PTR_W-1:0] w);
    return (p >= w) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                               input logic [CW-1:0]    n,
                                               input logic [CW-1:0]    d);
    logic [CW-1:0] s;
    s = CW'(p) + n;
    if (s >= d) s = s - d;
    return PTR_W'(s);
  endfunction

  assign depth_eff = CW'(wrap_q) + CW'(1);
  assign o_wr_ready = (count_q < depth_eff) && (state_q == LLR_IDLE);
  assign wr_acc = i_wr_en && o_wr_ready;
  assign rd_dist = llr_mod_dist(LLR_DW'(rd_q), LLR_DW'(tail_q), LLR_DW'(wrap_q));
  assign eseq_dist = llr_mod_dist(LLR_DW'(i_replay_eseq), LLR_DW'(tail_q), LLR_DW'(wrap_q));

  // Pointer/count bookkeeping and replay sequencing.
  always_comb begin
    state_d   = state_q;
    wrap_d    = wrap_q;
    head_d    = head_q;
    tail_d    = tail_q;
    rd_d      = rd_q;
    err_d     = 1'b0;
    done_d    = 1'b0;
    ram_re    = 1'b0;
    ram_raddr = rd_q;
    n_ack     = '0;

    if (i_ack_valid) n_ack = (CW'(i_ack_num) < count_q) ? CW'(i_ack_num) : count_q;
    // While replaying, never free the entry being replayed or anything after it.
    if ((state_q != LLR_IDLE) && (LLR_DW'(n_ack) > rd_dist)) n_ack = CW'(rd_dist);

    if (count_q == '0) wrap_d = i_wrap_value;
    if (wr_acc) head_d = ptr_inc(head_q, wrap_q);
    tail_d  = ptr_add(tail_q, n_ack, depth_eff);
    count_d = count_q + CW'(wr_acc) - n_ack;

    case (state_q)
      LLR_IDLE: begin
        if (i_replay_req) begin
          if ((i_replay_eseq <= wrap_q) && (eseq_dist < LLR_DW'(count_q))) begin
            rd_d      = i_replay_eseq;
            ram_re    = 1'b1;
            ram_raddr = i_replay_eseq;
            state_d   = LLR_SETUP;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LLR_SETUP: state_d = LLR_REPLAY;
      LLR_REPLAY: begin
        if (i_rd_ready) begin
          rd_d      = ptr_inc(rd_q, wrap_q);
          ram_re    = 1'b1;
          ram_raddr = rd_d;
          if (rd_d == head_q) begin
            state_d = LLR_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = LLR_IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= LLR_IDLE;
      wrap_q  <= PTR_W'(DEPTH - 1);
      head_q  <= '0;
      tail_q  <= '0;
      rd_q    <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wrap_q  <= wrap_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  cxl_llr_ram #(
    .W     (FLIT_W),
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_ram (
    .clk_i   (i_clk),
    .we_i    (wr_acc),
    .waddr_i (head_q),
    .wdata_i (i_wr_flit),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (o_rd_flit)
  );

  assign o_wr_ptr        = head_q;
  assign o_rd_valid      = (state_q == LLR_REPLAY);
  assign o_rd_seq        = rd_q;
  assign o_replay_active = (state_q != LLR_IDLE);
  assign o_replay_done   = done_q;
  assign o_replay_err    = err_q;
  assign o_consumed      = count_q;

`ifdef LLRB_HIGH_WATER_EN
  logic [CW-1:0] hwm_q, hwm_d;

  // Tracks the next count so the mark never lags o_consumed.
  always_comb begin
    hwm_d = hwm_q;
    if (i_hwm_clr) hwm_d = count_q;
    else if (count_d > hwm_q) hwm_d = count_d;
  end

  // High-water register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) hwm_q <= '0;
    else          hwm_q <= hwm_d;
  end

  assign o_high_water = hwm_q;
`else
  logic unused_hwm_clr;
  assign unused_hwm_clr = i_hwm_clr;
  assign o_high_water   = '0;
`endif

endmodule

// File: tb/tb_cxl_llr_buffer.sv
// Directed bench for cxl_llr_buffer, DEPTH=8, 32-bit flits.
module tb_cxl_llr_buffer;

  localparam int unsigned FW = 32;
  localparam int unsigned DP = 8;
  localparam int unsigned PW = 3;

  logic          clk, rst_n;
  logic [PW-1:0] wrap;
  logic          wr_en;
  logic [FW-1:0] wr_flit;
  logic          wr_ready;
  logic [PW-1:0] wr_ptr;
  logic          ack_valid;
  logic [PW-1:0] ack_num;
  logic          replay_req;
  logic [PW-1:0] replay_eseq;
  logic          rd_valid, rd_ready;
  logic [FW-1:0] rd_flit;
  logic [PW-1:0] rd_seq;
  logic          replay_active, replay_done, replay_err;
  logic [PW:0]   consumed, high_water;
  logic          hwm_clr;

  int vectors = 0;
  int miscompares = 0;

  cxl_llr_buffer #(.FLIT_W(FW), .DEPTH(DP), .PTR_W(PW)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_wrap_value    (wrap),
    .i_wr_en         (wr_en),
    .i_wr_flit       (wr_flit),
    .o_wr_ready      (wr_ready),
    .o_wr_ptr        (wr_ptr),
    .i_ack_valid     (ack_valid),
    .i_ack_num       (ack_num),
    .i_replay_req    (replay_req),
    .i_replay_eseq   (replay_eseq),
    .o_rd_valid      (rd_valid),
    .i_rd_ready      (rd_ready),
    .o_rd_flit       (rd_flit),
    .o_rd_seq        (rd_seq),
    .o_replay_active (replay_active),
    .o_replay_done   (replay_done),
    .o_replay_err    (replay_err),
    .o_consumed      (consumed),
    .o_high_water    (high_water),
    .i_hwm_clr       (hwm_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [PW-1:0] w);
    rst_n = 1'b0; wr_en = 1'b0; wr_flit = '0; ack_valid = 1'b0; ack_num = '0;
    replay_req = 1'b0; replay_eseq = '0; rd_ready = 1'b0; hwm_clr = 1'b0; wrap = w;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic wr(input logic [FW-1:0] d);
    wr_en = 1'b1; wr_flit = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic ack(input logic [PW-1:0] n);
    ack_valid = 1'b1; ack_num = n;
    tick();
    ack_valid = 1'b0;
  endtask

  task automatic req(input logic [PW-1:0] e);
    replay_req = 1'b1; replay_eseq = e;
    tick();
    replay_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_en = 1'b0; ack_valid = 1'b0; replay_req = 1'b0; rd_ready = 1'b0;
    hwm_clr = 1'b0; wrap = 3'd7; wr_flit = '0; ack_num = '0; replay_eseq = '0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({wr_ready, rd_valid, replay_active, replay_done, replay_err} !== 5'b10000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 10000",
               {wr_ready, rd_valid, replay_active, replay_done, replay_err});
    end
    vectors++;
    if (consumed !== 4'd0 || wr_ptr !== 3'd0 || high_water !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_counts: got consumed=%0d wr_ptr=%0d hwm=%0d expected 0/0/0",
               consumed, wr_ptr, high_water);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    do_reset(3'd7);
    for (int k = 0; k < 8; k++) wr(32'h1000_0000 + k);
    vectors++;
    if (wr_ready !== 1'b0 || consumed !== 4'd8 || wr_ptr !== 3'd0) begin
      miscompares++;
      $display("FAIL fill_full: got ready=%b consumed=%0d wr_ptr=%0d expected 0/8/0",
               wr_ready, consumed, wr_ptr);
    end
    wr(32'hDEAD_BEEF);
    vectors++;
    if (consumed !== 4'd8 || wr_ptr !== 3'd0) begin
      miscompares++;
      $display("FAIL fill_overflow: got consumed=%0d wr_ptr=%0d expected 8/0", consumed, wr_ptr);
    end
    rd_ready = 1'b1;
    req(3'd0);
    vectors++;
    if (rd_valid !== 1'b0 || replay_active !== 1'b1) begin
      miscompares++;
      $display("FAIL fill_setup: got valid=%b active=%b expected 0/1", rd_valid, replay_active);
    end
    tick();
    for (int k = 0; k < 8; k++) begin
      vectors++;
      if (rd_valid !== 1'b1 || rd_seq !== 3'(k) || rd_flit !== 32'h1000_0000 + k) begin
        miscompares++;
        $display("FAIL fill_replay: got v=%b seq=%0d flit=%h expected 1/%0d/%h",
                 rd_valid, rd_seq, rd_flit, k, 32'h1000_0000 + k);
      end
      tick();
    end
    vectors++;
    if (replay_done !== 1'b1 || rd_valid !== 1'b0 || replay_active !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_done: got done=%b valid=%b active=%b expected 1/0/0",
               replay_done, rd_valid, replay_active);
    end
    rd_ready = 1'b0;
    ack(3'd3);
    vectors++;
    if (consumed !== 4'd5 || wr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL fill_ack: got consumed=%0d ready=%b expected 5/1", consumed, wr_ready);
    end
  endtask

  task automatic test_wrap();
    logic [PW-1:0] es;
    do_reset(3'd5);
    for (int k = 0; k < 4; k++) wr(32'h2000_0000 + k);
    wr_en = 1'b1; wr_flit = 32'h2000_0004; ack_valid = 1'b1; ack_num = 3'd2;
    tick();
    wr_en = 1'b0; ack_valid = 1'b0;
    vectors++;
    if (consumed !== 4'd3 || wr_ptr !== 3'd5) begin
      miscompares++;
      $display("FAIL wrap_wr_ack: got consumed=%0d wr_ptr=%0d expected 3/5", consumed, wr_ptr);
    end
    wr(32'h2000_0005);
    vectors++;
    if (wr_ptr !== 3'd0 || consumed !== 4'd4) begin
      miscompares++;
      $display("FAIL wrap_ptr: got wr_ptr=%0d consumed=%0d expected 0/4", wr_ptr, consumed);
    end
    wr(32'h2000_0006);
    wr(32'h2000_0007);
    vectors++;
    if (consumed !== 4'd6 || wr_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_full: got consumed=%0d ready=%b expected 6/0", consumed, wr_ready);
    end
    ack(3'd3);
    wr(32'h2000_0008);
    wr(32'h2000_0009);
    vectors++;
    if (consumed !== 4'd5 || wr_ptr !== 3'd4) begin
      miscompares++;
      $display("FAIL wrap_refill: got consumed=%0d wr_ptr=%0d expected 5/4", consumed, wr_ptr);
    end
    rd_ready = 1'b1;
    req(3'd5);
    tick();
    for (int i = 0; i < 5; i++) begin
      es = (i == 0) ? 3'd5 : 3'(i - 1);
      vectors++;
      if (rd_valid !== 1'b1 || rd_seq !== es || rd_flit !== 32'h2000_0005 + i) begin
        miscompares++;
        $display("FAIL wrap_replay: got v=%b seq=%0d flit=%h expected 1/%0d/%h",
                 rd_valid, rd_seq, rd_flit, es, 32'h2000_0005 + i);
      end
      tick();
    end
    vectors++;
    if (replay_done !== 1'b1 || rd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_done: got done=%b valid=%b expected 1/0", replay_done, rd_valid);
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_stall_and_err();
    logic [7:0] pat;
    int exp;
    pat = 8'b1011_0010;
    do_reset(3'd7);
    for (int k = 0; k < 8; k++) wr(32'h3000_0000 + k);
    ack(3'd2);
    vectors++;
    if (consumed !== 4'd6) begin
      miscompares++;
      $display("FAIL stall_setup: got consumed=%0d expected 6", consumed);
    end
    rd_ready = 1'b0;
    req(3'd4);
    tick();
    exp = 4;
    for (int c = 0; c < 16; c++) begin
      vectors++;
      if (rd_valid !== 1'b1 || rd_seq !== 3'(exp) || rd_flit !== 32'h3000_0000 + exp) begin
        miscompares++;
        $display("FAIL stall_replay: got v=%b seq=%0d flit=%h expected 1/%0d/%h",
                 rd_valid, rd_seq, rd_flit, exp, 32'h3000_0000 + exp);
      end
      rd_ready = (c < 8) ? pat[c] : 1'b1;
      tick();
      if (rd_ready) exp++;
      if (exp == 8) break;
    end
    rd_ready = 1'b0;
    vectors++;
    if (replay_done !== 1'b1 || rd_valid !== 1'b0 || consumed !== 4'd6) begin
      miscompares++;
      $display("FAIL stall_done: got done=%b valid=%b consumed=%0d expected 1/0/6",
               replay_done, rd_valid, consumed);
    end
    req(3'd1);
    vectors++;
    if (replay_err !== 1'b1 || rd_valid !== 1'b0 || replay_active !== 1'b0) begin
      miscompares++;
      $display("FAIL err_window: got err=%b valid=%b active=%b expected 1/0/0",
               replay_err, rd_valid, replay_active);
    end
    tick();
    vectors++;
    if (replay_err !== 1'b0 || rd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL err_pulse: got err=%b valid=%b expected 0/0", replay_err, rd_valid);
    end
    do_reset(3'd7);
    req(3'd0);
    vectors++;
    if (replay_err !== 1'b1 || replay_active !== 1'b0) begin
      miscompares++;
      $display("FAIL err_empty: got err=%b active=%b expected 1/0", replay_err, replay_active);
    end
  endtask

  task automatic test_ack_clamp();
    do_reset(3'd7);
    for (int k = 0; k < 8; k++) wr(32'h4000_0000 + k);
    ack(3'd2);
    rd_ready = 1'b0;
    req(3'd5);
    tick();
    vectors++;
    if (rd_valid !== 1'b1 || rd_seq !== 3'd5) begin
      miscompares++;
      $display("FAIL clamp_start: got v=%b seq=%0d expected 1/5", rd_valid, rd_seq);
    end
    ack(3'd6);
    vectors++;
    if (consumed !== 4'd3) begin
      miscompares++;
      $display("FAIL clamp_ack: got consumed=%0d expected 3", consumed);
    end
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (rd_valid !== 1'b1 || rd_seq !== 3'(5 + i) || rd_flit !== 32'h4000_0005 + i) begin
        miscompares++;
        $display("FAIL clamp_replay: got v=%b seq=%0d flit=%h expected 1/%0d/%h",
                 rd_valid, rd_seq, rd_flit, 5 + i, 32'h4000_0005 + i);
      end
      tick();
    end
    rd_ready = 1'b0;
    vectors++;
    if (replay_done !== 1'b1) begin
      miscompares++;
      $display("FAIL clamp_done: got done=%b expected 1", replay_done);
    end
    req(3'd4);
    vectors++;
    if (replay_err !== 1'b1) begin
      miscompares++;
      $display("FAIL clamp_tail: got err=%b expected 1", replay_err);
    end
  endtask

  task automatic test_reset_mid_replay();
    do_reset(3'd7);
    for (int k = 0; k < 4; k++) wr(32'h5000_0000 + k);
    req(3'd0);
    tick();
    vectors++;
    if (rd_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_pre: got valid=%b expected 1", rd_valid);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({wr_ready, rd_valid, replay_active, replay_done, replay_err} !== 5'b10000) begin
      miscompares++;
      $display("FAIL midrst_flags: got %b expected 10000",
               {wr_ready, rd_valid, replay_active, replay_done, replay_err});
    end
    vectors++;
    if (consumed !== 4'd0 || wr_ptr !== 3'd0 || rd_seq !== 3'd0 || high_water !== 4'd0) begin
      miscompares++;
      $display("FAIL midrst_counts: got consumed=%0d wr_ptr=%0d seq=%0d hwm=%0d expected 0/0/0/0",
               consumed, wr_ptr, rd_seq, high_water);
    end
  endtask

  task automatic test_high_water();
    do_reset(3'd7);
    for (int k = 0; k < 7; k++) wr(32'h6000_0000 + k);
`ifdef LLRB_HIGH_WATER_EN
    vectors++;
    if (high_water !== 4'd7) begin
      miscompares++;
      $display("FAIL hwm_peak: got %0d expected 7", high_water);
    end
    ack(3'd4);
    vectors++;
    if (consumed !== 4'd3 || high_water !== 4'd7) begin
      miscompares++;
      $display("FAIL hwm_keep: got consumed=%0d hwm=%0d expected 3/7", consumed, high_water);
    end
    hwm_clr = 1'b1;
    tick();
    hwm_clr = 1'b0;
    vectors++;
    if (high_water !== 4'd3) begin
      miscompares++;
      $display("FAIL hwm_clr: got %0d expected 3", high_water);
    end
`else
    hwm_clr = 1'b1;
    tick();
    hwm_clr = 1'b0;
    vectors++;
    if (high_water !== 4'd0 || consumed !== 4'd7) begin
      miscompares++;
      $display("FAIL hwm_off: got hwm=%0d consumed=%0d expected 0/7", high_water, consumed);
    end
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_fill();
    test_wrap();
    test_stall_and_err();
    test_ack_clamp();
    test_reset_mid_replay();
    test_high_water();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cxl_llr_buffer.md
# cxl_llr_buffer

Parametrised link-layer retry buffer (LLRB) for the CXL link-layer retry path. It stores every transmitted flit (with CRC) under its sequence number and frees entries as full-ack counts arrive from the unpacker. On a retry request it replays the stored flits starting from the requested expected-sequence (ESEQ) number. It sits between the CRC generator and the TX output mux, under command of the retry controller, and generalises the fixed 528-bit / 256-entry buffer to configurable flit width, depth and runtime wrap value.

## Interface
Parameters:
- FLIT_W, 528, flit width including CRC
- DEPTH, 256, physical entries; power of two, 4..1024
- PTR_W, $clog2(DEPTH), pointer/sequence width

Ports (one clock `i_clk`; reset `i_rst_n` is asynchronous and active-low):
- i_clk  in  1  clock
- i_rst_n  in  1  async active-low reset
- i_wrap_value  in  PTR_W  last valid sequence number; effective depth = i_wrap_value+1
- i_wr_en  in  1  write request
- i_wr_flit  in  FLIT_W  flit to store
- o_wr_ready  out  1  write accepted this cycle when high
- o_wr_ptr  out  PTR_W  sequence number the next accepted write receives
- i_ack_valid  in  1  ack count valid (1-cycle pulse)
- i_ack_num  in  PTR_W  number of entries acknowledged
- i_replay_req  in  1  start replay (1-cycle pulse)
- i_replay_eseq  in  PTR_W  first sequence number to replay
- o_rd_valid  out  1  replay flit valid
- i_rd_ready  in  1  downstream accepts flit
- o_rd_flit  out  FLIT_W  replay flit
- o_rd_seq  out  PTR_W  sequence number of o_rd_flit
- o_replay_active  out  1  high from request acceptance until done
- o_replay_done  out  1  1-cycle pulse after the last replay handshake
- o_replay_err  out  1  1-cycle pulse when the ESEQ is outside the held window
- o_consumed  out  PTR_W+1  entries held
- o_high_water  out  PTR_W+1  peak o_consumed (see Configuration)
- i_hwm_clr  in  1  clear high-water mark

## Operation
- Pointers: head (write), tail (oldest unacked), rd (replay), plus a count register. All pointers wrap from wrap_eff to 0.
- wrap_eff is latched from i_wrap_value only while count==0. When it changes, head/tail/rd are not moved.
- Write: accepted when i_wr_en && o_wr_ready. Accepted flit goes to mem[head], head++ and count++.
- o_wr_ready = (count < wrap_eff+1) && state==IDLE.
- Ack: on i_ack_valid, free n = min(i_ack_num, count) entries; tail += n and count -= n, both modulo wrap_eff+1.
- Ack during replay: clamp n further so tail does not pass rd, i.e. n ≤ (rd - tail) mod (wrap_eff+1).
- Write and ack in the same cycle: count += 1 - n.
- FSM, IDLE → SETUP → REPLAY → IDLE:
  - IDLE: on i_replay_req, test whether (i_replay_eseq - tail) mod (wrap_eff+1) < count.
    - True: rd ← eseq, issue RAM read, go to SETUP.
    - False: pulse o_replay_err and stay IDLE. This includes count==0.
  - SETUP: RAM data returns; o_rd_valid rises; go to REPLAY.
  - REPLAY: on each handshake, rd++ and the next read is issued the same cycle, so there are no bubbles. When rd+1 == head on a handshake, drop o_rd_valid, pulse o_replay_done and go to IDLE.
- i_replay_req outside IDLE is ignored.
- o_rd_flit and o_rd_seq are held stable while o_rd_valid && !i_rd_ready.
- Replay does not free entries; only acks free them.

## Timing
- Reset values: pointers, count and o_consumed 0; o_wr_ptr 0; o_rd_valid, o_replay_active, o_replay_done, o_replay_err 0; o_high_water 0; o_wr_ready 1; state IDLE; wrap_eff DEPTH-1. RAM contents are not reset.
- Reset mid-replay aborts it immediately and all outputs take their reset values.
- Write latency: a flit is replayable the cycle after acceptance.
- o_consumed and o_wr_ptr update the cycle after a write or ack.
- Replay latency: o_rd_valid is first high 2 cycles after the i_replay_req cycle. Throughput is then 1 flit/cycle when i_rd_ready is held high.
- o_replay_active rises the cycle after the request and falls with the o_replay_done pulse.
- o_replay_err is asserted the cycle after the request.

## Configuration
- `LLRB_HIGH_WATER_EN` defined:
  - o_high_water tracks max(o_consumed) since reset.
  - i_hwm_clr loads it with the current o_consumed on the next cycle.
- Not defined: o_high_water is tied to 0, i_hwm_clr is ignored and no counter logic is built. The port list is unchanged.

## Structure
- Package cxl_llr_pkg holds:
  - the FSM state enum {LLR_IDLE, LLR_SETUP, LLR_REPLAY}
  - default FLIT_W/DEPTH constants
  - a modular-distance function used by the ack clamp and the ESEQ window check
- Sub-module cxl_llr_ram: simple dual-port RAM, synchronous write and synchronous read, 1-cycle read latency, no reset.

## Test plan
- DEPTH=8, wrap 7: write 8 flits → o_wr_ready=0 and o_consumed=8; 9th write is not stored; ack 3 → o_consumed=5 and o_wr_ready=1.
- wrap 5: write 10 flits with acks interleaved → o_wr_ptr goes 5→0; a replay from eseq 5 returns seq 5,0,1… with the matching data.
- 6 held entries, tail=2: replay eseq 4 with i_rd_ready toggling → flits 4..7 in order, held stable on stalls, done pulse after seq 7, o_consumed unchanged.
- Replay eseq 1 when tail=2 → o_replay_err 1 cycle later, no o_rd_valid; replay with count 0 → error.
- During replay at rd=5 with tail=2: ack 6 → tail clamps to 5; same-cycle write+ack(2) → count net −1.
- Assert i_rst_n low mid-REPLAY → all outputs at reset values; with `LLRB_HIGH_WATER_EN`, peak 7 is kept after acks and i_hwm_clr loads the current count.
